// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sequencing one ful_add cell
module ful_add (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic             cmsb_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             accept;
  logic             last_bit;

  // The only adder in the block: bit 0 of each operand plus the carry loop.
  ful_add u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign accept   = (state == IDLE) && req_valid;
  assign last_bit = (cnt == LAST);

  // Handshake flags come straight from the state register, never from inputs.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  // Result outputs read the registers directly and so hold their last values.
  assign rsp_sum  = sum_sr;
  assign rsp_cout = carry_q;
  assign rsp_ovf  = cmsb_q ^ carry_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: accept in IDLE, WIDTH bit cycles in RUN, wait for consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = RUN;
      RUN:  if (last_bit) state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial datapath: load on accept, shift one bit per RUN cycle, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sr    <= op_a;
      b_sr    <= op_b;
      carry_q <= cin;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
      carry_q <= fa_carry;
      if (last_bit) begin
        // carry register here is the carry entering the MSB
        cmsb_q <= carry_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
